core_sequencer: RTL and testbench
=================================

Name: core_sequencer

Overview:
- Parametrised successor of the single-pass core controller.
- Sequences the convolution core over a configurable number of input channels. Each channel runs: init pulse, weight phase, image phase, then a fixed pipeline-drain window.
- Adds continuous re-run mode, abort, a per-phase watchdog and error reporting.
- Sits between the top-level control interface and the core datapath. Drives the core's init/enable lines and the channel select for the weight/image address generators.

Parameters:
- N_CH, 4, maximum channel count per run (>=1).
- CH_W, 2, width of channel index; must satisfy 2**CH_W >= N_CH.
- PIPE_LAT, 3, drain cycles after image end (>=1).
- TO_W, 16, watchdog counter width.
- TIMEOUT, 0, max cycles allowed in a WEIGHT or IMAGE phase; 0 disables the watchdog.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- start_core_in  in  1  request a run; sampled in IDLE only.
- cfg_num_ch_in  in  CH_W+1  channels for this run (1..N_CH); latched on accepted start.
- cfg_cont_in  in  1  continuous mode; latched on accepted start.
- abort_in  in  1  terminate the run.
- weight_end_in  in  1  weight stream for the current channel finished.
- img_end_in  in  1  image stream for the current channel finished.
- start_core_out  out  1  one-cycle core init pulse per channel.
- en_core_out  out  1  core enable.
- end_core_out  out  1  sequencer idle / run finished.
- ch_sel_out  out  CH_W  current channel index.
- done_pulse_out  out  1  one cycle at the end of a complete run.
- busy_out  out  1  not in IDLE.
- err_out  out  1  sticky error flag.

Behaviour:
- All outputs are Moore-decoded from registered state and counters. There are no combinational input-to-output paths.
- Reset: state=IDLE, ch_idx=0, drain/watchdog counters=0, latched cfg=0, err_out=0. Outputs: start_core_out=0, en_core_out=0, end_core_out=1, ch_sel_out=0, done_pulse_out=0, busy_out=0.
- rst has priority over every other input in every state, including mid-run.
- States:
  - IDLE: end=1, en=0. If start_core_in=1 and 1<=cfg_num_ch_in<=N_CH: latch cfg, clear err_out, ch_idx=0, go to START.
  - IDLE, invalid cfg: if start_core_in=1 with cfg_num_ch_in=0 or >N_CH, set err_out and stay in IDLE.
  - START (exactly 1 cycle): start_core_out=1, en=1. Next state is WEIGHT; watchdog cleared.
  - WEIGHT: en=1. weight_end_in=1 goes to IMAGE. weight_end_in and img_end_in together go directly to DRAIN. img_end_in alone is ignored.
  - IMAGE: en=1. img_end_in=1 goes to DRAIN and loads drain_cnt=PIPE_LAT-1. weight_end_in is ignored.
  - DRAIN: en=1; lasts exactly PIPE_LAT cycles. On the last cycle: if ch_idx < num_ch-1, increment ch_idx and go to START; otherwise go to DONE.
  - DONE (exactly 1 cycle): done_pulse_out=1, end_core_out=1, en=0. If latched cont=1, set ch_idx=0 and go to START; otherwise go to IDLE.
- busy_out=1 in every state except IDLE.
- ch_sel_out = ch_idx in all states.
- Watchdog (TIMEOUT>0):
  - Counter clears on entry to WEIGHT and on entry to IMAGE, and increments each cycle in those states.
  - When it reaches TIMEOUT with no end strobe seen: set err_out and go to IDLE. No done pulse; ch_idx=0.
  - The counter saturates; it never wraps.
- abort_in=1 in any non-IDLE state: go to IDLE next cycle, en=0, ch_idx=0, no done pulse, err_out unchanged. abort has priority over end strobes and over the watchdog. In IDLE, abort_in=1 blocks acceptance of a simultaneous start.
- start_core_in outside IDLE is ignored. Continuous mode stops only via abort or rst.
- Single-channel run latency: start accepted at cycle t gives START at t+1, WEIGHT from t+2. The minimum run ends with DONE at t+2+2+PIPE_LAT, with end strobes arriving on the first cycle of each phase.

Test Plan:
- Reset, then N_CH=4, PIPE_LAT=3, cfg_num_ch_in=2, cont=0, start at cycle 0. weight_end 3 cycles into WEIGHT, img_end 5 cycles into IMAGE, per channel. Expect:
  - start_core_out pulses twice, with ch_sel_out 0 then 1;
  - en high for each 3-cycle drain;
  - a single done_pulse_out;
  - return to IDLE with end_core_out=1.
- cfg_num_ch_in=0, then cfg_num_ch_in=5 (N_CH=4) with start -> err_out=1, state stays IDLE, en never asserted. A following valid start (cfg=1) clears err_out and runs.
- weight_end_in and img_end_in asserted together in WEIGHT -> next state DRAIN, skipping IMAGE. img_end_in alone in WEIGHT -> no transition.
- abort_in mid-IMAGE on channel 2 of 3 -> next cycle IDLE, en=0, ch_sel_out=0, no done pulse. abort coincident with img_end_in -> abort wins.
- TIMEOUT=8, hold WEIGHT with no weight_end -> on the 8th WEIGHT cycle err_out=1, then IDLE, busy_out=0.
- cont=1, cfg=1 -> DONE pulses repeatedly, each followed by START with no IDLE cycle between. abort terminates the loop. rst asserted mid-DRAIN -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/core_sequencer_if.sv
// Control-side bundle between the top-level controller and the convolution core sequencer.
// The sequencer takes the slave view; whoever drives runs takes the master view.
interface core_sequencer_if #(
  parameter int CH_W = 2
);
  logic            start_core_in;
  logic [CH_W:0]   cfg_num_ch_in;
  logic            cfg_cont_in;
  logic            abort_in;
  logic            weight_end_in;
  logic            img_end_in;
  logic            start_core_out;
  logic            en_core_out;
  logic            end_core_out;
  logic [CH_W-1:0] ch_sel_out;
  logic            done_pulse_out;
  logic            busy_out;
  logic            err_out;

  modport master (
    output start_core_in, cfg_num_ch_in, cfg_cont_in, abort_in, weight_end_in, img_end_in,
    input  start_core_out, en_core_out, end_core_out, ch_sel_out, done_pulse_out, busy_out, err_out
  );

  modport slave (
    input  start_core_in, cfg_num_ch_in, cfg_cont_in, abort_in, weight_end_in, img_end_in,
    output start_core_out, en_core_out, end_core_out, ch_sel_out, done_pulse_out, busy_out, err_out
  );
endinterface

// File: rtl/core_sequencer.sv
// Multi-channel sequencer for the convolution core: init pulse, weight phase, image phase and
// pipeline drain per channel, with continuous re-run, abort, per-phase watchdog and sticky error.
module core_sequencer #(
  parameter int N_CH     = 4,
  parameter int CH_W     = 2,
  parameter int PIPE_LAT = 3,
  parameter int TO_W     = 16,
  parameter int TIMEOUT  = 0
) (
  input  logic               clk,
  input  logic               rst,
  core_sequencer_if.slave    bus
);

  localparam int              DC_W       = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [DC_W-1:0] DRAIN_LOAD = DC_W'(PIPE_LAT - 1);
  localparam logic [CH_W:0]   MAX_CH     = (CH_W + 1)'(N_CH);
  localparam logic [TO_W-1:0] TO_LIM     = TO_W'(TIMEOUT);
  localparam bit              WD_EN      = (TIMEOUT > 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WEIGHT,
    S_IMAGE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CH_W-1:0] ch_idx_q, ch_idx_d;
  logic [DC_W-1:0] drain_cnt_q, drain_cnt_d;
  logic [TO_W-1:0] wd_cnt_q, wd_cnt_d;
  logic [CH_W:0]   num_ch_q, num_ch_d;
  logic            cont_q, cont_d;
  logic            err_q, err_d;

  logic [TO_W-1:0] wd_inc;
  logic            wd_expired;
  logic            ch_last;
  logic            cfg_ok;

  // Watchdog count holds at all-ones instead of wrapping back to zero.
  function automatic logic [TO_W-1:0] sat_inc(input logic [TO_W-1:0] v);
    return (&v) ? v : v + TO_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ch_idx_q    <= '0;
      drain_cnt_q <= '0;
      wd_cnt_q    <= '0;
      num_ch_q    <= '0;
      cont_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_idx_q    <= ch_idx_d;
      drain_cnt_q <= drain_cnt_d;
      wd_cnt_q    <= wd_cnt_d;
      num_ch_q    <= num_ch_d;
      cont_q      <= cont_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ch_idx_d    = ch_idx_q;
    drain_cnt_d = drain_cnt_q;
    wd_cnt_d    = wd_cnt_q;
    num_ch_d    = num_ch_q;
    cont_d      = cont_q;
    err_d       = err_q;

    wd_inc     = sat_inc(wd_cnt_q);
    wd_expired = WD_EN && (wd_inc == TO_LIM);
    ch_last    = (({1'b0, ch_idx_q} + (CH_W + 1)'(1)) >= num_ch_q);
    cfg_ok     = (bus.cfg_num_ch_in != '0) && (bus.cfg_num_ch_in <= MAX_CH);

    // Abort outranks end strobes and the watchdog in every active state.
    if (state_q != S_IDLE && bus.abort_in) begin
      state_d     = S_IDLE;
      ch_idx_d    = '0;
      wd_cnt_d    = '0;
      drain_cnt_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.start_core_in && !bus.abort_in) begin
            if (cfg_ok) begin
              num_ch_d = bus.cfg_num_ch_in;
              cont_d   = bus.cfg_cont_in;
              err_d    = 1'b0;
              ch_idx_d = '0;
              state_d  = S_START;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        S_START: begin
          wd_cnt_d = '0;
          state_d  = S_WEIGHT;
        end
        S_WEIGHT: begin
          wd_cnt_d = wd_inc;
          if (bus.weight_end_in && bus.img_end_in) begin
            drain_cnt_d = DRAIN_LOAD;
            state_d     = S_DRAIN;
          end else if (bus.weight_end_in) begin
            wd_cnt_d = '0;
            state_d  = S_IMAGE;
          end else if (wd_expired) begin
            err_d    = 1'b1;
            ch_idx_d = '0;
            wd_cnt_d = '0;
            state_d  = S_IDLE;
          end
        end
        S_IMAGE: begin
          wd_cnt_d = wd_inc;
          if (bus.img_end_in) begin
            drain_cnt_d = DRAIN_LOAD;
            state_d     = S_DRAIN;
          end else if (wd_expired) begin
            err_d    = 1'b1;
            ch_idx_d = '0;
            wd_cnt_d = '0;
            state_d  = S_IDLE;
          end
        end
        S_DRAIN: begin
          if (drain_cnt_q == '0) begin
            if (ch_last) begin
              state_d = S_DONE;
            end else begin
              ch_idx_d = ch_idx_q + CH_W'(1);
              state_d  = S_START;
            end
          end else begin
            drain_cnt_d = drain_cnt_q - DC_W'(1);
          end
        end
        S_DONE: begin
          if (cont_q) begin
            ch_idx_d = '0;
            state_d  = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign bus.start_core_out = (state_q == S_START);
  assign bus.en_core_out    = (state_q == S_START) || (state_q == S_WEIGHT) ||
                              (state_q == S_IMAGE) || (state_q == S_DRAIN);
  assign bus.end_core_out   = (state_q == S_IDLE) || (state_q == S_DONE);
  assign bus.ch_sel_out     = ch_idx_q;
  assign bus.done_pulse_out = (state_q == S_DONE);
  assign bus.busy_out       = (state_q != S_IDLE);
  assign bus.err_out        = err_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboard bench for core_sequencer: expected channel indices of init and done pulses are queued
// when a run is launched and consumed by a monitor as the sequencer emits them.
module tb_core_sequencer;
  localparam int N_CH     = 4;
  localparam int CH_W     = 2;
  localparam int PIPE_LAT = 3;
  localparam int TIMEOUT  = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  core_sequencer_if #(.CH_W(CH_W)) bus ();

  core_sequencer #(
    .N_CH(N_CH), .CH_W(CH_W), .PIPE_LAT(PIPE_LAT), .TO_W(16), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  int start_q[$];
  int done_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_o(input string tag, input logic s, input logic e, input logic nd,
                          input logic [CH_W-1:0] c, input logic d, input logic b);
    check_eq({tag, "_start"}, bus.start_core_out, s);
    check_eq({tag, "_en"},    bus.en_core_out,    e);
    check_eq({tag, "_end"},   bus.end_core_out,   nd);
    check_eq({tag, "_ch"},    bus.ch_sel_out,     c);
    check_eq({tag, "_done"},  bus.done_pulse_out, d);
    check_eq({tag, "_busy"},  bus.busy_out,       b);
  endtask

  // Called in a START cycle; returns in the cycle after the drain window (START or DONE).
  task automatic run_ch(input int wd, input int id, input logic [CH_W-1:0] ch);
    expect_o("ch_start", 1'b1, 1'b1, 1'b0, ch, 1'b0, 1'b1);
    for (int k = 1; k <= wd; k++) begin
      step();
      expect_o("weight", 1'b0, 1'b1, 1'b0, ch, 1'b0, 1'b1);
      if (k == wd) bus.weight_end_in = 1'b1;
    end
    for (int k = 1; k <= id; k++) begin
      step();
      bus.weight_end_in = 1'b0;
      expect_o("image", 1'b0, 1'b1, 1'b0, ch, 1'b0, 1'b1);
      if (k == id) bus.img_end_in = 1'b1;
    end
    for (int k = 1; k <= PIPE_LAT; k++) begin
      step();
      bus.img_end_in = 1'b0;
      expect_o("drain", 1'b0, 1'b1, 1'b0, ch, 1'b0, 1'b1);
    end
    step();
  endtask

  task automatic launch(input logic [CH_W:0] n, input logic cont);
    bus.cfg_num_ch_in = n;
    bus.cfg_cont_in   = cont;
    bus.start_core_in = 1'b1;
    step();
    bus.start_core_in = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (bus.start_core_out === 1'b1) begin
        if (start_q.size() == 0) check_eq("start_unexpected", bus.start_core_out, 0);
        else check_eq("start_ch_sb", bus.ch_sel_out, start_q.pop_front());
      end
      if (bus.done_pulse_out === 1'b1) begin
        if (done_q.size() == 0) check_eq("done_unexpected", bus.done_pulse_out, 0);
        else check_eq("done_ch_sb", bus.ch_sel_out, done_q.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b1;
    bus.start_core_in = 1'b0;
    bus.cfg_num_ch_in = '0;
    bus.cfg_cont_in   = 1'b0;
    bus.abort_in      = 1'b0;
    bus.weight_end_in = 1'b0;
    bus.img_end_in    = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    expect_o("reset", 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
    check_eq("reset_err", bus.err_out, 1'b0);

    // Over-range channel count flags an error and stays idle; reset clears the flag.
    launch(3'd5, 1'b0);
    expect_o("cfg5", 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
    check_eq("cfg5_err", bus.err_out, 1'b1);
    step();
    check_eq("cfg5_en_hold", bus.en_core_out, 1'b0);
    check_eq("cfg5_busy_hold", bus.busy_out, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    expect_o("rst_idle", 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
    check_eq("rst_idle_err", bus.err_out, 1'b0);

    launch(3'd0, 1'b0);
    expect_o("cfg0", 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
    check_eq("cfg0_err", bus.err_out, 1'b1);

    // Valid start clears the error; strobes on the 8th phase cycle beat the watchdog.
    start_q.push_back(0);
    done_q.push_back(0);
    launch(3'd1, 1'b0);
    check_eq("valid_err_clr", bus.err_out, 1'b0);
    run_ch(8, 8, 2'd0);
    expect_o("c_done", 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b1);
    step();
    expect_o("c_idle", 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0);

    // Two-channel single run.
    start_q.push_back(0);
    start_q.push_back(1);
    done_q.push_back(1);
    launch(3'd2, 1'b0);
    run_ch(3, 5, 2'd0);
    run_ch(3, 5, 2'd1);
    expect_o("two_done", 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b1);
    step();
    expect_o("two_idle", 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0);

    // img_end alone in WEIGHT is ignored; both strobes together skip IMAGE.
    start_q.push_back(0);
    done_q.push_back(0);
    launch(3'd1, 1'b0);
    expect_o("both_st", 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1);
    step();
    bus.img_end_in = 1'b1;
    step();
    bus.img_end_in = 1'b0;
    expect_o("img_only", 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1);
    step();
    bus.weight_end_in = 1'b1;
    bus.img_end_in    = 1'b1;
    for (int k = 1; k <= PIPE_LAT; k++) begin
      step();
      bus.weight_end_in = 1'b0;
      bus.img_end_in    = 1'b0;
      expect_o("both_drain", 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1);
    end
    step();
    expect_o("both_done", 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b1);
    step();

    // Abort mid-IMAGE on the second of three channels.
    start_q.push_back(0);
    start_q.push_back(1);
    launch(3'd3, 1'b0);
    run_ch(1, 1, 2'd0);
    expect_o("ab_st1", 1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1);
    step();
    bus.weight_end_in = 1'b1;
    step();
    bus.weight_end_in = 1'b0;
    step();
    bus.abort_in = 1'b1;
    step();
    bus.abort_in = 1'b0;
    expect_o("abort", 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
    step();
    expect_o("abort_hold", 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0);

    // Abort coincident with img_end: abort wins.
    start_q.push_back(0);
    launch(3'd1, 1'b0);
    step();
    bus.weight_end_in = 1'b1;
    step();
    bus.weight_end_in = 1'b0;
    bus.img_end_in    = 1'b1;
    bus.abort_in      = 1'b1;
    step();
    bus.img_end_in = 1'b0;
    bus.abort_in   = 1'b0;
    expect_o("abort_img", 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0);

    // Watchdog expiry in WEIGHT of the second channel.
    start_q.push_back(0);
    start_q.push_back(1);
    launch(3'd2, 1'b0);
    run_ch(1, 1, 2'd0);
    for (int k = 1; k <= TIMEOUT; k++) begin
      step();
      expect_o("wd_wait", 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1);
      check_eq("wd_wait_err", bus.err_out, 1'b0);
    end
    step();
    expect_o("wd_fire", 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
    check_eq("wd_fire_err", bus.err_out, 1'b1);

    // Continuous mode: DONE goes straight back to START until aborted.
    for (int k = 0; k < 3; k++) start_q.push_back(0);
    done_q.push_back(0);
    done_q.push_back(0);
    launch(3'd1, 1'b1);
    check_eq("cont_err_clr", bus.err_out, 1'b0);
    run_ch(1, 1, 2'd0);
    expect_o("cont_done1", 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b1);
    step();
    run_ch(2, 1, 2'd0);
    expect_o("cont_done2", 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b1);
    step();
    expect_o("cont_restart", 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1);
    bus.abort_in = 1'b1;
    step();
    bus.abort_in = 1'b0;
    expect_o("cont_abort", 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0);

    // Reset in the middle of a drain window.
    start_q.push_back(0);
    launch(3'd2, 1'b1);
    step();
    bus.weight_end_in = 1'b1;
    step();
    bus.weight_end_in = 1'b0;
    bus.img_end_in    = 1'b1;
    step();
    bus.img_end_in = 1'b0;
    expect_o("pre_rst_drain", 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    expect_o("mid_rst", 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
    check_eq("mid_rst_err", bus.err_out, 1'b0);
    step();
    expect_o("post_rst", 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0);

    check_eq("start_q_left", start_q.size(), 0);
    check_eq("done_q_left", done_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
